uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameters SHALL be as follows.
- DWIDTH, default 8: byte width.
- NREQ, default 4: number of requesters, range 2..8.
- TIMEOUT, default 16: maximum cycles allowed for tx_busy to rise after a launch.
REQ-002 Ports SHALL be as follows.
- clk  in  1  single clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester byte-pending flag.
- req_data  in  NREQ*DWIDTH  requester i byte in bits [i*DWIDTH +: DWIDTH].
- tx_busy  in  1  busy output of the UART transmitter.
- grant  out  NREQ  one-hot, one-cycle pulse: requester byte captured.
- tx_data  out  DWIDTH  byte presented to the transmitter p_data.
- tx_valid  out  1  data_valid pulse to the transmitter.
- active_id  out  clog2(NREQ)  index of the requester currently being served.
- done  out  1  one-cycle pulse: frame completed.
- err  out  1  one-cycle pulse: launch timed out.

Function
REQ-003 The FSM SHALL have four states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-004 In IDLE with req != 0, the block SHALL select the winner in round-robin order, searching from ptr+1 upward with wrap at NREQ.
REQ-005 In that same IDLE cycle, the block SHALL:
- pulse grant[winner],
- register req_data[winner] into tx_data,
- register winner into active_id and ptr,
- move to LAUNCH.
REQ-006 In IDLE with req == 0, the block SHALL hold all state and keep grant, tx_valid, done and err at 0.
REQ-007 LAUNCH SHALL assert tx_valid for exactly one cycle, then move to WAIT_BUSY with the timeout counter cleared.
REQ-008 WAIT_BUSY SHALL move to WAIT_DONE on the first cycle tx_busy=1.
REQ-009 If tx_busy is still 0 when the counter reaches TIMEOUT-1, WAIT_BUSY SHALL pulse err and return to IDLE; no done is issued.
REQ-010 The timeout counter SHALL saturate and SHALL never wrap.
REQ-011 WAIT_DONE SHALL pulse done and return to IDLE on the first cycle tx_busy=0.
REQ-012 tx_data and active_id SHALL remain stable from LAUNCH through the cycle done or err pulses.
REQ-013 At most one grant bit SHALL be high in any cycle, and only in IDLE.
REQ-014 The minimum spacing between consecutive grants SHALL be 4 cycles (IDLE→LAUNCH→WAIT_BUSY→WAIT_DONE→IDLE).
REQ-015 Changes to req or req_data after grant SHALL have no effect on the byte in flight.
REQ-016 Simultaneous requests SHALL be served fairly: each active requester is served once per NREQ completions.
REQ-017 A requester holding req high after its grant SHALL be re-served only after all other active requesters.
REQ-018 ptr SHALL update only on grant, so a timed-out requester is not re-favoured.
REQ-019 If tx_busy is already 1 in IDLE, the block SHALL still grant and launch; the timeout then guards the launch.
REQ-020 Outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-021 On rst=1 at a clk edge, the block SHALL:
- enter IDLE,
- drive grant, tx_valid, done and err to 0,
- clear tx_data, active_id and the counter to 0,
- set ptr to NREQ-1, so requester 0 wins first.
REQ-022 Reset SHALL take priority over every state, including mid-frame. A subsequent tx_busy=1 SHALL be ignored in IDLE.

Structure
REQ-023 The shared uart_pkg SHALL hold the state encoding localparams and the default TIMEOUT.
REQ-024 Round-robin selection SHALL be a combinational sub-module uart_rr_pick with inputs req and ptr, and outputs a one-hot vector, an index and an any flag.
REQ-025 The block SHALL instantiate nothing else. It connects externally to uart_tx data_valid, p_data and busy.

Verification
REQ-026 Post-reset with req=4'b0001 and data 8'hA5, and a model busy high for 10 cycles → grant=0001 at cycle 0, tx_valid at cycle 1, tx_data=A5, done once, active_id=0.
REQ-027 req=4'b1111 held, each frame 10 busy cycles → grant sequence 0,1,2,3,0, with exactly one done per grant.
REQ-028 req=4'b0101 after requester 2 is served → next grant goes to 0, not 2.
REQ-029 tx_busy tied 0, TIMEOUT=16 → err pulses exactly 16 cycles after tx_valid, no done, next grant rotates.
REQ-030 rst asserted during WAIT_DONE → next cycle IDLE, all outputs 0, following grant goes to requester 0.
REQ-031 req_data[0] changed from 8'h3C to 8'hFF one cycle after grant → tx_data stays 3C until done.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM state encoding and default launch timeout.
// Latency: none, this file holds declarations only.
// Backpressure: not applicable.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LAUNCH    = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        LAUNCH    = ST_LAUNCH,
        WAIT_BUSY = ST_WAIT_BUSY,
        WAIT_DONE = ST_WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: lowest requester strictly above ptr, else the lowest requester overall.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to act on the pick.
module uart_rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [NREQ:0]   upto_ptr;
    logic [NREQ-1:0] above_mask;
    logic [NREQ-1:0] req_above;
    logic [NREQ-1:0] cand;

    // Bits 0..ptr set; everything above ptr is eligible first, then wrap to the bottom.
    assign upto_ptr   = ({{NREQ{1'b0}}, 1'b1} << ({1'b0, ptr} + 1'b1)) - 1'b1;
    assign above_mask = ~upto_ptr[NREQ-1:0];
    assign req_above  = req & above_mask;
    assign cand       = (req_above != '0) ? req_above : req;
    assign onehot     = cand & (~cand + 1'b1);
    assign any        = |req;

    // Encode the one-hot winner into an index.
    always_comb begin
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (onehot[i]) begin
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Arbitrates NREQ byte requesters onto a single UART transmitter and tracks each frame to completion.
// Latency: grant registered 1 cycle after the winning IDLE cycle, tx_valid one cycle after grant.
// Backpressure: one frame in flight; requesters wait in IDLE until done or err ends the frame.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int DWIDTH  = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DWIDTH-1:0]   req_data,
    input  logic                     tx_busy,
    output logic [NREQ-1:0]          grant,
    output logic [DWIDTH-1:0]        tx_data,
    output logic                     tx_valid,
    output logic [$clog2(NREQ)-1:0]  active_id,
    output logic                     done,
    output logic                     err
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [DWIDTH-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic [IW-1:0]     active_id_q, active_id_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [NREQ-1:0]   pick_oh;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    uart_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Next-state and registered-output decode; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = '0;
        tx_valid_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        tx_data_d   = tx_data_q;
        active_id_d = active_id_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                // tx_busy is deliberately ignored here; a stuck busy is caught by the launch timeout.
                if (pick_any) begin
                    grant_d     = pick_oh;
                    tx_data_d   = req_data[pick_idx*DWIDTH +: DWIDTH];
                    active_id_d = pick_idx;
                    ptr_d       = pick_idx;
                    state_d     = LAUNCH;
                end
            end
            LAUNCH: begin
                tx_valid_d = 1'b1;
                cnt_d      = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q >= CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset wins over any frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            tx_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tx_data_q   <= '0;
            active_id_q <= '0;
            ptr_q       <= IW'(NREQ - 1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            tx_valid_q  <= tx_valid_d;
            done_q      <= done_d;
            err_q       <= err_d;
            tx_data_q   <= tx_data_d;
            active_id_q <= active_id_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign grant     = grant_q;
    assign tx_data   = tx_data_q;
    assign tx_valid  = tx_valid_q;
    assign active_id = active_id_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed plus random bench for uart_tx_arb against a round-robin reference model.
// Latency: grant observed one cycle after IDLE decision; timeout checked at 16 cycles after tx_valid.
// Backpressure: a simple UART busy model raises tx_busy for busy_len cycles after each tx_valid.
module tb_uart_tx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        tx_busy;
    logic [3:0]  grant;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [1:0]  active_id;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int busy_len = 10;
    int bcnt  = 0;
    bit mon_en = 1'b0;
    int mptr  = 3;

    uart_tx_arb #(.DWIDTH(8), .NREQ(4), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .active_id (active_id),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=timeout expected=event", tag);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Reference arbiter: first requester found walking upward from the last winner, wrapping at 4.
    function automatic int rr_model(input int last, input logic [3:0] r);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    function automatic int oh_index(input logic [3:0] g);
        int idx = -1;
        for (int i = 0; i < 4; i++) if (g[i]) idx = i;
        return idx;
    endfunction

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 60; k++) begin
            if (grant != 4'b0) begin
                idx = oh_index(grant);
                return;
            end
            step();
        end
        timeout_fail("wait_grant");
    endtask

    task automatic wait_end(output bit d, output bit e);
        d = 1'b0;
        e = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (done || err) begin
                d = done;
                e = err;
                return;
            end
            step();
        end
        timeout_fail("wait_end");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mptr = 3;
    endtask

    // UART transmitter stand-in: busy for busy_len cycles after each accepted tx_valid.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end else if (tx_valid === 1'b1 && busy_len > 0) begin
                tx_busy = 1'b1;
                bcnt = busy_len;
            end
        end
    end

    // Cycle-by-cycle invariants: grant at most one-hot, done and err never together.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                chk("grant_onehot0", 32'($onehot0(grant)), 32'd1);
                chk("done_err_excl", 32'(done & err), 32'd0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, tv, nd, exp_i;
        bit d, e;
        int exp_seq [5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        logic [7:0] exp_data;
        int blen;

        rst = 1'b1;
        req = 4'b0;
        req_data = 32'h0;

        // Reset state
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_active_id", 32'(active_id), 32'd0);
        rst = 1'b0;
        mptr = 3;
        mon_en = 1'b1;

        // Single requester, byte A5, 10 busy cycles
        busy_len = 10;
        req = 4'b0001;
        req_data[7:0] = 8'hA5;
        wait_grant(g);
        chk("single_grant_vec", 32'(grant), 32'h1);
        chk("single_tx_data", 32'(tx_data), 32'hA5);
        chk("single_active_id", 32'(active_id), 32'd0);
        req = 4'b0;
        step();
        chk("single_tx_valid_hi", 32'(tx_valid), 32'd1);
        step();
        chk("single_tx_valid_lo", 32'(tx_valid), 32'd0);
        wait_end(d, e);
        chk("single_done", 32'(d), 32'd1);
        chk("single_no_err", 32'(e), 32'd0);
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (done) nd++;
        end
        chk("single_done_once", 32'(nd), 32'd0);
        mptr = 0;

        // All four requesting: rotation 0,1,2,3,0 from reset
        do_reset();
        req = 4'b1111;
        busy_len = 10;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            chk("rot_grant", 32'(g), 32'(exp_seq[k]));
            mptr = g;
            if (k == 4) req = 4'b0;
            wait_end(d, e);
            chk("rot_done", 32'(d), 32'd1);
        end

        // Requester 2 served, then 0 and 2 both request: 0 wins
        req = 4'b0100;
        wait_grant(g);
        chk("fair_first", 32'(g), 32'd2);
        mptr = g;
        req = 4'b0;
        wait_end(d, e);
        req = 4'b0101;
        exp_i = rr_model(mptr, req);
        wait_grant(g);
        chk("fair_next", 32'(g), 32'(exp_i));
        chk("fair_next_is0", 32'(g), 32'd0);
        mptr = g;
        req = 4'b0;
        wait_end(d, e);

        // Transmitter never goes busy: err exactly 16 cycles after tx_valid
        busy_len = 0;
        req = 4'b0010;
        wait_grant(g);
        chk("to_grant", 32'(g), 32'd1);
        mptr = g;
        req = 4'b0;
        step();
        chk("to_tx_valid", 32'(tx_valid), 32'd1);
        tv = cyc;
        wait_end(d, e);
        chk("to_err", 32'(e), 32'd1);
        chk("to_no_done", 32'(d), 32'd0);
        chk("to_delay", 32'(cyc - tv), 32'd16);
        busy_len = 10;
        req = 4'b0011;
        exp_i = rr_model(mptr, req);
        wait_grant(g);
        chk("to_rotate", 32'(g), 32'(exp_i));
        mptr = g;
        req = 4'b0;
        wait_end(d, e);

        // Byte change after grant does not reach the frame in flight
        req = 4'b0001;
        req_data[7:0] = 8'h3C;
        wait_grant(g);
        chk("hold_grant", 32'(g), 32'(rr_model(mptr, 4'b0001)));
        mptr = g;
        step();
        req_data[7:0] = 8'hFF;
        req = 4'b0;
        wait_end(d, e);
        chk("hold_tx_data", 32'(tx_data), 32'h3C);
        chk("hold_done", 32'(d), 32'd1);

        // Reset in the middle of WAIT_DONE
        busy_len = 20;
        req = 4'b0100;
        wait_grant(g);
        chk("midrst_grant", 32'(g), 32'd2);
        req = 4'b0;
        for (int k = 0; k < 6; k++) step();
        chk("midrst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        mptr = 3;
        chk("midrst_grant0", 32'(grant), 32'd0);
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_err", 32'(err), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'd0);
        chk("midrst_active_id", 32'(active_id), 32'd0);
        nd = 0;
        for (int k = 0; k < 25; k++) begin
            step();
            if (done || err || tx_valid) nd++;
        end
        chk("midrst_quiet", 32'(nd), 32'd0);
        busy_len = 10;
        req = 4'b1111;
        wait_grant(g);
        chk("midrst_next0", 32'(g), 32'd0);
        mptr = g;
        req = 4'b0;
        wait_end(d, e);

        // Random traffic against the model
        for (int it = 0; it < 40; it++) begin
            r = 4'($urandom_range(1, 15));
            req = r;
            req_data = $urandom;
            blen = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 8));
            busy_len = blen;
            exp_i = rr_model(mptr, r);
            exp_data = req_data[exp_i*8 +: 8];
            wait_grant(g);
            chk("rnd_grant", 32'(g), 32'(exp_i));
            chk("rnd_tx_data", 32'(tx_data), 32'(exp_data));
            chk("rnd_active_id", 32'(active_id), 32'(exp_i));
            mptr = exp_i;
            step();
            req_data = $urandom;
            if ($urandom_range(0, 1) == 0) req = 4'b0;
            wait_end(d, e);
            chk("rnd_done", 32'(d), 32'(blen != 0));
            chk("rnd_err", 32'(e), 32'(blen == 0));
            chk("rnd_hold", 32'(tx_data), 32'(exp_data));
        end
        req = 4'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
